// File: rtl/tpu_pkg.sv
// Shared types and default constants for the TPU matrix-multiply controller.
package tpu_pkg;

  localparam int TPU_DIM    = 4;
  localparam int TPU_DATA_W = 32;

  // Matrix indices are 5 bits wide, so DIM can be at most 32.
  typedef logic [4:0] index_t;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

endpackage

// File: rtl/tpu_mac.sv
// Single multiply-accumulate: sum = acc + a*b, keeping the low DATA_W bits.
// This is kept as a separate module so a pipelined multiplier can replace it.
module tpu_mac
  import tpu_pkg::*;
#(
  parameter int DATA_W = TPU_DATA_W
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  logic [DATA_W-1:0] prod;

  // Same-width operands, so the product and the sum both wrap modulo 2^DATA_W.
  always_comb begin
    prod = a * b;
    sum  = acc + prod;
  end

endmodule

// File: rtl/tpu_mmu_ctrl.sv
// TPU matrix unit: holds A, B and C, and runs C += A*B one MAC per cycle.
// It stalls the pipeline with busy_o and pulses done_o when it finishes.
module tpu_mmu_ctrl
  import tpu_pkg::*;
#(
  parameter int DIM    = TPU_DIM,
  parameter int DATA_W = TPU_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              wr_en_a_i,
  input  logic              wr_en_b_i,
  input  logic              wr_en_c_i,
  input  logic [4:0]        row_i,
  input  logic [4:0]        col_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [4:0]        rd_row_i,
  input  logic [4:0]        rd_col_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o
);

  // The array address width is trimmed to what DIM needs. The full 5-bit
  // indices are range-checked first, so the trimmed bits never alias.
  localparam int         IW    = (DIM > 1) ? $clog2(DIM) : 1;
  localparam index_t     LAST  = index_t'(DIM - 1);
  localparam logic [5:0] DIM_W = 6'(DIM);

  logic [DATA_W-1:0] mat_a [DIM][DIM];
  logic [DATA_W-1:0] mat_b [DIM][DIM];
  logic [DATA_W-1:0] mat_c [DIM][DIM];

  state_t state;
  index_t i, j, k;

  logic              idle;
  logic              wr_ok;
  logic              rd_ok;
  logic [IW-1:0]     wr_r, wr_c, rd_r, rd_c;
  logic [IW-1:0]     ii, jj, kk;
  logic [DATA_W-1:0] mac_sum;

  // Decode the write and read addresses and apply their range checks.
  always_comb begin
    idle  = (state == IDLE);
    wr_ok = ({1'b0, row_i} < DIM_W) && ({1'b0, col_i} < DIM_W);
    rd_ok = ({1'b0, rd_row_i} < DIM_W) && ({1'b0, rd_col_i} < DIM_W);
    wr_r  = row_i[IW-1:0];
    wr_c  = col_i[IW-1:0];
    rd_r  = rd_row_i[IW-1:0];
    rd_c  = rd_col_i[IW-1:0];
    ii    = i[IW-1:0];
    jj    = j[IW-1:0];
    kk    = k[IW-1:0];
  end

  tpu_mac #(.DATA_W(DATA_W)) u_mac (
    .acc (mat_c[ii][jj]),
    .a   (mat_a[ii][kk]),
    .b   (mat_b[kk][jj]),
    .sum (mac_sum)
  );

  // Sequencer FSM. k is the fastest counter, then j, then i. busy_o and
  // done_o are registered together with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state  <= MAC;
            busy_o <= 1'b1;
            i      <= '0;
            j      <= '0;
            k      <= '0;
          end
        end
        MAC: begin
          if (k == LAST) begin
            k <= '0;
            if (j == LAST) begin
              j <= '0;
              if (i == LAST) begin
                i      <= '0;
                state  <= DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                i <= i + index_t'(1);
              end
            end else begin
              j <= j + index_t'(1);
            end
          end else begin
            k <= k + index_t'(1);
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  // Operand storage. A and B change only through writes made while IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mat_a[r][c] <= '0;
          mat_b[r][c] <= '0;
        end
      end
    end else if (idle && wr_ok) begin
      if (wr_en_a_i) mat_a[wr_r][wr_c] <= data_i;
      if (wr_en_b_i) mat_b[wr_r][wr_c] <= data_i;
    end
  end

  // Accumulator storage and the registered read port. A read of the element
  // being written at the same edge returns its old value.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mat_c[r][c] <= '0;
        end
      end
      rd_data_o <= '0;
    end else begin
      if (state == MAC) begin
        mat_c[ii][jj] <= mac_sum;
      end else if (idle && wr_ok && wr_en_c_i) begin
        mat_c[wr_r][wr_c] <= data_i;
      end
      rd_data_o <= rd_ok ? mat_c[rd_r][rd_c] : '0;
    end
  end

endmodule

// File: tb/tb_tpu_mmu_ctrl.sv
// Directed self-checking bench for tpu_mmu_ctrl with DIM=4 and DATA_W=32.
module tb_tpu_mmu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic        wr_en_a_i = 1'b0;
  logic        wr_en_b_i = 1'b0;
  logic        wr_en_c_i = 1'b0;
  logic [4:0]  row_i = '0;
  logic [4:0]  col_i = '0;
  logic [31:0] data_i = '0;
  logic [4:0]  rd_row_i = '0;
  logic [4:0]  rd_col_i = '0;
  logic [31:0] rd_data_o;
  logic        busy_o;
  logic        done_o;

  int n_cmp = 0;
  int n_err = 0;

  tpu_mmu_ctrl #(.DIM(4), .DATA_W(32)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start_i   (start_i),
    .wr_en_a_i (wr_en_a_i),
    .wr_en_b_i (wr_en_b_i),
    .wr_en_c_i (wr_en_c_i),
    .row_i     (row_i),
    .col_i     (col_i),
    .data_i    (data_i),
    .rd_row_i  (rd_row_i),
    .rd_col_i  (rd_col_i),
    .rd_data_o (rd_data_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk_i = ~clk_i;

  // All helper tasks start and end just after a falling edge.
  task automatic write_elem(input logic a, input logic b, input logic c,
                            input int r, input int col, input logic [31:0] d);
    wr_en_a_i = a;
    wr_en_b_i = b;
    wr_en_c_i = c;
    row_i     = 5'(r);
    col_i     = 5'(col);
    data_i    = d;
    @(negedge clk_i);
    wr_en_a_i = 1'b0;
    wr_en_b_i = 1'b0;
    wr_en_c_i = 1'b0;
  endtask

  task automatic read_c(input int r, input int col, output logic [31:0] v);
    rd_row_i = 5'(r);
    rd_col_i = 5'(col);
    @(negedge clk_i);
    v = rd_data_o;
  endtask

  task automatic clear_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_elem(1'b1, 1'b1, 1'b1, r, c, 32'h0);
  endtask

  task automatic load_identity();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        write_elem(1'b1, 1'b0, 1'b0, r, c, (r == c) ? 32'd1 : 32'd0);
        write_elem(1'b0, 1'b1, 1'b0, r, c, 32'(r * 4 + c));
      end
  endtask

  // Pulse start_i together with any write enables the caller has already
  // set up, then watch a fixed window of 70 cycles. Sample n=1 is the cycle
  // right after the start edge. If inject_at > 0, a start plus a write of
  // A[0][0]=0xFF is driven during sample inject_at.
  task automatic run_start(input int inject_at, output int busy_cnt,
                           output int done_cnt, output int done_at);
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    start_i  = 1'b1;
    @(negedge clk_i);
    start_i   = 1'b0;
    wr_en_a_i = 1'b0;
    wr_en_b_i = 1'b0;
    wr_en_c_i = 1'b0;
    for (int n = 1; n <= 70; n++) begin
      if (busy_o === 1'b1) busy_cnt++;
      if (done_o === 1'b1) begin
        done_cnt++;
        done_at = n;
      end
      if (n == inject_at) begin
        start_i   = 1'b1;
        wr_en_a_i = 1'b1;
        row_i     = 5'd0;
        col_i     = 5'd0;
        data_i    = 32'hFF;
      end
      @(negedge clk_i);
      start_i   = 1'b0;
      wr_en_a_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", busy_o);
    end
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_done: got %b, expected 0", done_o);
    end
    n_cmp++;
    if (rd_data_o !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_rd: got %h, expected 0", rd_data_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    read_c(3, 3, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL reset_c33: got %h, expected 0", v);
    end
  endtask

  task automatic test_identity();
    int bc, dc, da;
    logic [31:0] v;
    load_identity();
    run_start(0, bc, dc, da);
    n_cmp++;
    if (bc !== 64) begin
      n_err++;
      $display("[TB] FAIL ident_busy_len: got %0d, expected 64", bc);
    end
    n_cmp++;
    if (dc !== 1) begin
      n_err++;
      $display("[TB] FAIL ident_done_cnt: got %0d, expected 1", dc);
    end
    n_cmp++;
    if (da !== 65) begin
      n_err++;
      $display("[TB] FAIL ident_done_at: got %0d, expected 65", da);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        read_c(r, c, v);
        n_cmp++;
        if (v !== 32'(r * 4 + c)) begin
          n_err++;
          $display("[TB] FAIL ident_c[%0d][%0d]: got %0d, expected %0d", r, c, v, r * 4 + c);
        end
      end
  endtask

  task automatic test_accumulate();
    int bc, dc, da;
    logic [31:0] v;
    run_start(0, bc, dc, da);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        read_c(r, c, v);
        n_cmp++;
        if (v !== 32'(2 * (r * 4 + c))) begin
          n_err++;
          $display("[TB] FAIL accum_c[%0d][%0d]: got %0d, expected %0d", r, c, v, 2 * (r * 4 + c));
        end
      end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_elem(1'b0, 1'b0, 1'b1, r, c, 32'h0);
    run_start(0, bc, dc, da);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        read_c(r, c, v);
        n_cmp++;
        if (v !== 32'(r * 4 + c)) begin
          n_err++;
          $display("[TB] FAIL rerun_c[%0d][%0d]: got %0d, expected %0d", r, c, v, r * 4 + c);
        end
      end
  endtask

  task automatic test_wrap();
    int bc, dc, da;
    logic [31:0] v;
    logic [31:0] exp_c [4][4];
    clear_all();
    write_elem(1'b1, 1'b1, 1'b0, 0, 0, 32'h0001_0000);
    write_elem(1'b1, 1'b1, 1'b0, 1, 1, 32'hFFFF_FFFF);
    write_elem(1'b1, 1'b1, 1'b0, 2, 2, 32'h0000_0001);
    write_elem(1'b0, 1'b0, 1'b1, 2, 2, 32'hFFFF_FFFF);
    run_start(0, bc, dc, da);
    // 2^32 wraps to 0; (2^32-1)^2 wraps to 1; (2^32-1) + 1 wraps to 0.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_c[r][c] = 32'h0;
    exp_c[1][1] = 32'h1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        read_c(r, c, v);
        n_cmp++;
        if (v !== exp_c[r][c]) begin
          n_err++;
          $display("[TB] FAIL wrap_c[%0d][%0d]: got %h, expected %h", r, c, v, exp_c[r][c]);
        end
      end
  endtask

  task automatic test_range();
    logic [31:0] v;
    // C currently holds 0 everywhere except C[1][1]=1.
    write_elem(1'b0, 1'b0, 1'b1, 5, 1, 32'hDEAD_BEEF);
    write_elem(1'b0, 1'b0, 1'b1, 1, 5, 32'hDEAD_BEEF);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        read_c(r, c, v);
        n_cmp++;
        if (v !== ((r == 1 && c == 1) ? 32'h1 : 32'h0)) begin
          n_err++;
          $display("[TB] FAIL range_c[%0d][%0d]: got %h, expected %h", r, c, v,
                   (r == 1 && c == 1) ? 32'h1 : 32'h0);
        end
      end
    read_c(5, 1, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL range_rd_row5: got %h, expected 0", v);
    end
    // A read and a write of the same element at the same edge.
    rd_row_i = 5'd2;
    rd_col_i = 5'd3;
    write_elem(1'b0, 1'b0, 1'b1, 2, 3, 32'h55);
    n_cmp++;
    if (rd_data_o !== 32'h0) begin
      n_err++;
      $display("[TB] FAIL rw_same_old: got %h, expected 0", rd_data_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (rd_data_o !== 32'h55) begin
      n_err++;
      $display("[TB] FAIL rw_same_new: got %h, expected 55", rd_data_o);
    end
  endtask

  task automatic test_ignore_busy();
    int bc, dc, da;
    logic [31:0] v;
    clear_all();
    load_identity();
    run_start(10, bc, dc, da);
    n_cmp++;
    if (bc !== 64) begin
      n_err++;
      $display("[TB] FAIL ign_busy_len: got %0d, expected 64", bc);
    end
    n_cmp++;
    if (dc !== 1) begin
      n_err++;
      $display("[TB] FAIL ign_done_cnt: got %0d, expected 1", dc);
    end
    for (int c = 0; c < 4; c++) begin
      read_c(0, c, v);
      n_cmp++;
      if (v !== 32'(c)) begin
        n_err++;
        $display("[TB] FAIL ign_c[0][%0d]: got %0d, expected %0d", c, v, c);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bc, dc, da;
    int dcount;
    logic [31:0] v;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (20) @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL rmid_busy: got %b, expected 0", busy_o);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    dcount = 0;
    for (int n = 0; n < 70; n++) begin
      if (done_o !== 1'b0) dcount++;
      @(negedge clk_i);
    end
    n_cmp++;
    if (dcount !== 0) begin
      n_err++;
      $display("[TB] FAIL rmid_done: got %0d pulses, expected 0", dcount);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        read_c(r, c, v);
        n_cmp++;
        if (v !== 32'h0) begin
          n_err++;
          $display("[TB] FAIL rmid_c[%0d][%0d]: got %h, expected 0", r, c, v);
        end
      end
    load_identity();
    run_start(0, bc, dc, da);
    n_cmp++;
    if (bc !== 64) begin
      n_err++;
      $display("[TB] FAIL rmid_rerun_busy: got %0d, expected 64", bc);
    end
    read_c(3, 2, v);
    n_cmp++;
    if (v !== 32'd14) begin
      n_err++;
      $display("[TB] FAIL rmid_rerun_c32: got %0d, expected 14", v);
    end
  endtask

  task automatic test_same_cycle();
    int bc, dc, da;
    logic [31:0] v;
    clear_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        write_elem(1'b0, 1'b1, 1'b0, r, c, 32'h1);
    wr_en_a_i = 1'b1;
    row_i     = 5'd1;
    col_i     = 5'd1;
    data_i    = 32'd3;
    run_start(0, bc, dc, da);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        read_c(r, c, v);
        n_cmp++;
        if (v !== ((r == 1) ? 32'd3 : 32'd0)) begin
          n_err++;
          $display("[TB] FAIL same_c[%0d][%0d]: got %0d, expected %0d", r, c, v, (r == 1) ? 3 : 0);
        end
      end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    @(negedge clk_i);
    test_reset();
    test_identity();
    test_accumulate();
    test_wrap();
    test_range();
    test_ignore_busy();
    test_reset_mid();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
